nibble_add_sequencer: RTL
=========================

Name: nibble_add_sequencer

Overview:
Multi-cycle operand sequencer that sits directly upstream of the team's 4-bit adder stage. It accepts a WIDTH-bit add request over a valid/ready handshake. It then drives one nibble per cycle (A, B, carry-in) into the external 4-bit adder, least-significant first, and collects the returned Sum/Cout nibble by nibble. The assembled WIDTH-bit result and final carry are presented on a valid/ready output handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
NIBBLES, WIDTH/4, derived local constant; number of adder passes per operation.

Ports:
clk  input  1  single clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in for nibble 0.
nib_a  output  4  A nibble to 4-bit adder.
nib_b  output  4  B nibble to 4-bit adder.
nib_cin  output  1  carry-in to 4-bit adder.
nib_sum  input  4  Sum from 4-bit adder; combinational, same cycle.
nib_cout  input  1  Cout from 4-bit adder; combinational, same cycle.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  assembled sum.
out_cout  output  1  carry-out of the top nibble.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While reset_n=0: state=IDLE, all registers cleared, in_ready=1, out_valid=0, out_sum=0, out_cout=0, nib_*=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in_a/in_b/in_cin into a_reg/b_reg/carry_reg, set idx=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Drive nib_a=a_reg[4*idx+:4], nib_b=b_reg[4*idx+:4], nib_cin=carry_reg.
  - Each edge: sum_reg[4*idx+:4]<=nib_sum, carry_reg<=nib_cout, idx<=idx+1.
  - When idx==NIBBLES-1: out_cout<=nib_cout and go to DONE; idx does not wrap into another pass.
- DONE:
  - out_valid=1.
  - out_sum=sum_reg and out_cout are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready rises the cycle after the handshake; no same-cycle bypass.
- Outside RUN, nib_a/nib_b/nib_cin=0.
- Latency: out_valid is high starting NIBBLES edges after the accepting edge (4 for WIDTH=16).
- Minimum spacing between accepts: NIBBLES+2 edges.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, exact, WIDTH+1 bits. Carry propagates between nibbles only via carry_reg.
- out_sum is only meaningful while out_valid=1. sum_reg keeps stale upper nibbles mid-RUN; consumers must not sample it before out_valid.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No out_valid is produced for it; after release the block is in IDLE.
- WIDTH=4: single RUN cycle.

Test Plan:
- Bench ties nib_* to a combinational 4-bit adder model.
- Test 1: WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_sum=0x5555, out_cout=0; out_valid high exactly 4 edges after accept; nib_a sequence 4,3,2,1.
- Test 2: a=0xFFFF, b=0x0001, cin=0 -> out_sum=0x0000, out_cout=1; nib_cin sequence 0,1,1,1.
- Test 3: a=0xFFFF, b=0x0000, cin=1 -> out_sum=0x0000, out_cout=1; a=0x8000, b=0x8000, cin=0 -> 0x0000, cout=1.
- Test 4: out_ready held low 3 cycles in DONE -> out_valid, out_sum, out_cout stable; in_ready=0; a new in_valid is ignored; released -> IDLE next edge, in_ready=1.
- Test 5: reset_n pulsed low after 2 RUN cycles of 0x00FF+0x0001 -> outputs clear asynchronously, no out_valid. A following 0x0001+0x0002 request -> 0x0003, cout=0.
- Test 6: back-to-back requests with in_valid held high and out_ready=1 -> accepts spaced 6 edges apart; results 0x1111+0x2222=0x3333, then 0xABCD+0x5433=0x0000 with cout=1.

Source files
------------

// File: rtl/nibble_add_sequencer_if.sv
// Handshake and nibble-adder bus between the sequencer, its requester/consumer
// and the external 4-bit adder stage.
interface nibble_add_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic             nib_cin;
   logic [3:0]       nib_sum;
   logic             nib_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, nib_sum, nib_cout, out_ready,
      output in_ready, nib_a, nib_b, nib_cin, out_valid, out_sum, out_cout
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, nib_sum, nib_cout, out_ready,
      input  in_ready, nib_a, nib_b, nib_cin, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Sequences a WIDTH-bit add through an external 4-bit adder, one nibble per
// cycle, LSB first, and presents the assembled result on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one nibble per edge through the external adder
// DONE  | result held on out_sum/out_cout until out_ready
module nibble_add_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   nibble_add_sequencer_if.slave  bus,
   output logic                   busy
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [IDXW-1:0]  idx_q;
   logic [3:0]       nib_a_q;
   logic [3:0]       nib_b_q;
   logic             nib_cin_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             out_cout_q;
   logic             busy_q;
   logic             last_d;

   assign last_d = (idx_q == IDXW'(NIBBLES - 1));

   // a_q/b_q hold the not-yet-issued nibbles, so the next nibble is always
   // the low 4 bits; nib_cin_q doubles as the inter-nibble carry register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         nib_a_q     <= '0;
         nib_b_q     <= '0;
         nib_cin_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_cout_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.in_a >> 4;
                  b_q        <= bus.in_b >> 4;
                  nib_a_q    <= bus.in_a[3:0];
                  nib_b_q    <= bus.in_b[3:0];
                  nib_cin_q  <= bus.in_cin;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               sum_q[4*idx_q +: 4] <= bus.nib_sum;
               if (last_d) begin
                  out_cout_q  <= bus.nib_cout;
                  out_valid_q <= 1'b1;
                  nib_a_q     <= '0;
                  nib_b_q     <= '0;
                  nib_cin_q   <= 1'b0;
                  state_q     <= DONE;
               end else begin
                  idx_q     <= idx_q + IDXW'(1);
                  nib_a_q   <= a_q[3:0];
                  nib_b_q   <= b_q[3:0];
                  a_q       <= a_q >> 4;
                  b_q       <= b_q >> 4;
                  nib_cin_q <= bus.nib_cout;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.nib_a     = nib_a_q;
   assign bus.nib_b     = nib_b_q;
   assign bus.nib_cin   = nib_cin_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = out_cout_q;
   assign busy          = busy_q;
endmodule
